// File: rtl/axis_pkg.sv
// Shared constants and elaboration-time helpers for the AXI-Stream FIFO/skid buffer.
package axis_pkg;

    localparam int PKT_CUT = 0;
    localparam int PKT_SAF = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

    // Level counters must represent 0..DEPTH inclusive.
    function automatic int lvl_width(input int depth);
        return clog2(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Circular store of {last,data} words; read is asynchronous so a same-cycle write never disturbs the word being read.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter int WORD_W = 9,
    parameter int DEPTH  = 4,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [WORD_W-1:0] rd_data,
    output logic              empty
);

    logic [WORD_W-1:0] store_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            store_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = store_r[rd_ptr_r];
    assign empty   = (count_r == (AW+1)'(0));

endmodule

// File: rtl/axis_fifo_skid.sv
// AXI-Stream buffer: circular store plus registered output stage, registered s_ready,
// optional store-and-forward packet mode with forced release when the buffer fills.
module axis_fifo_skid
    import axis_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int PKT_MODE = 0,
    localparam int LVL_W   = lvl_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [LVL_W-1:0]  level,
    output logic [LVL_W-1:0]  pkt_cnt,
    output logic              pkt_overrun
);

    localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic              s_ready_r;
    logic [DATA_W-1:0] m_data_r;
    logic              m_valid_r;
    logic              m_last_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  pkt_cnt_r;
    logic              pkt_overrun_r;
    logic              mid_pkt_r;

    logic              accept_s;
    logic              consume_s;
    logic              out_free_s;
    logic              pkt_done_s;
    logic              overrun_s;
    logic              allow_s;
    logic              load_s;
    logic              from_mem_s;
    logic              mem_wr_s;
    logic              mem_empty_s;
    logic [DATA_W:0]   mem_rd_s;
    logic [DATA_W:0]   load_word_s;
    logic [LVL_W-1:0]  level_next_s;
    logic [LVL_W-1:0]  pkt_next_s;

    // Store sized to DEPTH so packet mode can fill completely before a forced release.
    axis_fifo_mem #(
        .WORD_W (DATA_W + 1),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (mem_wr_s),
        .wr_data ({s_last, s_data}),
        .rd_en   (from_mem_s),
        .rd_data (mem_rd_s),
        .empty   (mem_empty_s)
    );

    // Handshakes, occupancy, packet gating and output-stage load selection.
    always_comb begin
        level_next_s = level_r;
        pkt_next_s   = LVL_ZERO;
        overrun_s    = 1'b0;
        allow_s      = 1'b1;

        accept_s   = s_valid & s_ready_r;
        consume_s  = m_valid_r & m_ready;
        out_free_s = ~m_valid_r | m_ready;
        pkt_done_s = consume_s & m_last_r;

        if (accept_s && !consume_s) begin
            level_next_s = level_r + LVL_ONE;
        end else if (consume_s && !accept_s) begin
            level_next_s = level_r - LVL_ONE;
        end else begin
            level_next_s = level_r;
        end

        if (PKT_MODE == PKT_SAF) begin
            // A full buffer holding no complete packet would deadlock, so release its head.
            overrun_s = out_free_s & ~mid_pkt_r & (level_r == LVL_FULL) & (pkt_cnt_r == LVL_ZERO);
            allow_s   = mid_pkt_r | overrun_s |
                        ((pkt_cnt_r - (pkt_done_s ? LVL_ONE : LVL_ZERO)) != LVL_ZERO);
            case ({accept_s & s_last, pkt_done_s})
                2'b10:   pkt_next_s = pkt_cnt_r + LVL_ONE;
                2'b01:   pkt_next_s = pkt_cnt_r - LVL_ONE;
                default: pkt_next_s = pkt_cnt_r;
            endcase
        end else begin
            overrun_s  = 1'b0;
            allow_s    = 1'b1;
            pkt_next_s = LVL_ZERO;
        end

        // Store head takes priority; bypass only when the store is empty.
        load_s      = out_free_s & allow_s & (~mem_empty_s | accept_s);
        from_mem_s  = load_s & ~mem_empty_s;
        mem_wr_s    = accept_s & ~(load_s & mem_empty_s);
        load_word_s = from_mem_s ? mem_rd_s : {s_last, s_data};
    end

    // Output stage, counters and registered ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data_r      <= {DATA_W{1'b0}};
            m_valid_r     <= 1'b0;
            m_last_r      <= 1'b0;
            s_ready_r     <= 1'b0;
            level_r       <= LVL_ZERO;
            pkt_cnt_r     <= LVL_ZERO;
            pkt_overrun_r <= 1'b0;
            mid_pkt_r     <= 1'b0;
        end else begin
            if (load_s) begin
                m_data_r  <= load_word_s[DATA_W-1:0];
                m_last_r  <= load_word_s[DATA_W];
                m_valid_r <= 1'b1;
                mid_pkt_r <= ~load_word_s[DATA_W];
            end else if (out_free_s) begin
                m_data_r  <= {DATA_W{1'b0}};
                m_last_r  <= 1'b0;
                m_valid_r <= 1'b0;
            end else begin
                m_data_r  <= m_data_r;
                m_last_r  <= m_last_r;
                m_valid_r <= m_valid_r;
            end
            level_r       <= level_next_s;
            s_ready_r     <= (level_next_s < LVL_FULL);
            pkt_cnt_r     <= pkt_next_s;
            pkt_overrun_r <= overrun_s & load_s;
        end
    end

    assign s_ready     = s_ready_r;
    assign m_data      = m_data_r;
    assign m_valid     = m_valid_r;
    assign m_last      = m_last_r;
    assign level       = level_r;
    assign pkt_cnt     = pkt_cnt_r;
    assign pkt_overrun = pkt_overrun_r;

endmodule

// File: tb/tb_axis_fifo_skid.sv
// Directed bench for axis_fifo_skid: a cut-through and a packet-mode instance checked against
// a handshake scoreboard plus level/pkt_cnt models.
module tb_axis_fifo_skid;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] c_s_data = '0, c_m_data;
    logic          c_s_valid = 1'b0, c_s_last = 1'b0, c_m_ready = 1'b0;
    logic          c_s_ready, c_m_valid, c_m_last, c_pkt_overrun;
    logic [LW-1:0] c_level, c_pkt_cnt;

    logic [DW-1:0] p_s_data = '0, p_m_data;
    logic          p_s_valid = 1'b0, p_s_last = 1'b0, p_m_ready = 1'b0;
    logic          p_s_ready, p_m_valid, p_m_last, p_pkt_overrun;
    logic [LW-1:0] p_level, p_pkt_cnt;

    axis_fifo_skid #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(0)) u_cut (
        .clk(clk), .reset_n(reset_n),
        .s_data(c_s_data), .s_valid(c_s_valid), .s_last(c_s_last), .s_ready(c_s_ready),
        .m_data(c_m_data), .m_valid(c_m_valid), .m_last(c_m_last), .m_ready(c_m_ready),
        .level(c_level), .pkt_cnt(c_pkt_cnt), .pkt_overrun(c_pkt_overrun)
    );

    axis_fifo_skid #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_MODE(1)) u_pkt (
        .clk(clk), .reset_n(reset_n),
        .s_data(p_s_data), .s_valid(p_s_valid), .s_last(p_s_last), .s_ready(p_s_ready),
        .m_data(p_m_data), .m_valid(p_m_valid), .m_last(p_m_last), .m_ready(p_m_ready),
        .level(p_level), .pkt_cnt(p_pkt_cnt), .pkt_overrun(p_pkt_overrun)
    );

    int checks = 0;
    int errors = 0;
    logic [DW:0] q_c[$];
    logic [DW:0] q_p[$];
    int lvl_c = 0, lvl_p = 0, pc_p = 0, ovr_p = 0, cons_c = 0;
    logic hold_c = 1'b0, hold_p = 1'b0;
    logic [DW:0] held_c = '0, held_p = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; the next posedge applies them.
    task automatic step();
        logic [DW:0] w;
        #1;
        chk("c_level", c_level, lvl_c);
        chk("c_pkt_cnt_zero", c_pkt_cnt, 32'd0);
        chk("c_no_overrun", c_pkt_overrun, 32'd0);
        if (hold_c) chk("c_hold", {c_m_valid, c_m_last, c_m_data}, {1'b1, held_c});
        if (!c_m_valid) chk("c_idle_zero", {c_m_last, c_m_data}, 32'd0);
        if (c_s_valid && c_s_ready) begin
            q_c.push_back({c_s_last, c_s_data});
            lvl_c++;
        end
        if (c_m_valid && c_m_ready) begin
            lvl_c--;
            cons_c++;
            if (q_c.size() == 0) chk("c_spurious", q_c.size(), 32'd1);
            else begin
                w = q_c.pop_front();
                chk("c_order", {c_m_last, c_m_data}, w);
            end
        end
        hold_c = c_m_valid && !c_m_ready;
        held_c = {c_m_last, c_m_data};

        chk("p_level", p_level, lvl_p);
        chk("p_pkt_cnt", p_pkt_cnt, pc_p);
        if (hold_p) chk("p_hold", {p_m_valid, p_m_last, p_m_data}, {1'b1, held_p});
        if (!p_m_valid) chk("p_idle_zero", {p_m_last, p_m_data}, 32'd0);
        if (p_pkt_overrun) ovr_p++;
        if (p_s_valid && p_s_ready) begin
            q_p.push_back({p_s_last, p_s_data});
            lvl_p++;
            if (p_s_last) pc_p++;
        end
        if (p_m_valid && p_m_ready) begin
            lvl_p--;
            if (p_m_last) pc_p--;
            if (q_p.size() == 0) chk("p_spurious", q_p.size(), 32'd1);
            else begin
                w = q_p.pop_front();
                chk("p_order", {p_m_last, p_m_data}, w);
            end
        end
        hold_p = p_m_valid && !p_m_ready;
        held_p = {p_m_last, p_m_data};
        @(negedge clk);
    endtask

    task automatic send_c(input logic [DW-1:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        c_s_data = d; c_s_last = last; c_s_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            acc = c_s_ready;
            step();
            if (acc) break;
        end
        chk("c_send_accept", acc, 32'd1);
        c_s_valid = 1'b0; c_s_last = 1'b0; c_s_data = '0;
    endtask

    task automatic send_p(input logic [DW-1:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        p_s_data = d; p_s_last = last; p_s_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            acc = p_s_ready;
            step();
            if (acc) break;
        end
        chk("p_send_accept", acc, 32'd1);
        p_s_valid = 1'b0; p_s_last = 1'b0; p_s_data = '0;
    endtask

    task automatic drain();
        c_m_ready = 1'b1; p_m_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (c_level == 0 && p_level == 0) break;
            step();
        end
        chk("drain_c", c_level, 32'd0);
        chk("drain_p", p_level, 32'd0);
        chk("drain_queues", q_c.size() + q_p.size(), 32'd0);
    endtask

    // Asserts reset between edges, checks the asynchronous clear, releases at a negedge.
    task automatic do_reset();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_c", {c_m_data, c_m_valid, c_m_last, c_s_ready, c_level, c_pkt_cnt, c_pkt_overrun}, 32'd0);
        chk("rst_p", {p_m_data, p_m_valid, p_m_last, p_s_ready, p_level, p_pkt_cnt, p_pkt_overrun}, 32'd0);
        q_c.delete(); q_p.delete();
        lvl_c = 0; lvl_p = 0; pc_p = 0;
        hold_c = 1'b0; hold_p = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_sready_low", {c_s_ready, p_s_ready}, 32'd0);
        @(negedge clk);
        chk("rel_sready_high", {c_s_ready, p_s_ready}, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [DW-1:0] e;
        logic acc;
        int idx, cons0, ovr0;

        @(negedge clk);
        do_reset();

        // Test 1: back-to-back stream, one-cycle latency, no bubbles.
        c_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = 8'h11 + 8'(i);
            c_s_data = e; c_s_valid = 1'b1;
            chk("t1_sready", c_s_ready, 32'd1);
            step();
            chk("t1_latency", {c_m_valid, c_m_data}, {1'b1, e});
            chk("t1_level", c_level, 32'd1);
        end
        c_s_valid = 1'b0;
        drain();

        // Test 2: fill with downstream stalled, then release.
        c_m_ready = 1'b0;
        idx = 0;
        for (int n = 0; n < 6; n++) begin
            c_s_data = 8'hA0 + 8'(idx); c_s_valid = 1'b1;
            acc = c_s_ready;
            step();
            if (acc) idx++;
        end
        chk("t2_accepted", idx, 32'd4);
        chk("t2_sready_full", c_s_ready, 32'd0);
        chk("t2_level_full", c_level, 32'd4);
        chk("t2_head", {c_m_valid, c_m_data}, {1'b1, 8'hA0});
        c_m_ready = 1'b1;
        for (int n = 0; n < 20 && idx < 6; n++) begin
            c_s_data = 8'hA0 + 8'(idx); c_s_valid = 1'b1;
            acc = c_s_ready;
            step();
            if (acc) idx++;
        end
        chk("t2_all_accepted", idx, 32'd6);
        c_s_valid = 1'b0;
        drain();

        // Test 3: full buffer with both sides active.
        c_m_ready = 1'b0;
        e = 8'hB0;
        for (int n = 0; n < 10 && c_level != 4; n++) begin
            c_s_data = e; c_s_valid = 1'b1;
            acc = c_s_ready;
            step();
            if (acc) e = e + 8'd1;
        end
        chk("t3_filled", c_level, 32'd4);
        c_m_ready = 1'b1;
        cons0 = cons_c;
        for (int n = 0; n < 10; n++) begin
            c_s_data = e; c_s_valid = 1'b1;
            acc = c_s_ready;
            step();
            if (acc) e = e + 8'd1;
            chk("t3_level_bound", (c_level <= 4), 32'd1);
        end
        chk("t3_throughput", cons_c - cons0, 32'd10);
        c_s_valid = 1'b0;
        drain();

        // Test 4: store-and-forward gates output until the packet is complete.
        p_m_ready = 1'b1;
        send_p(8'h01, 1'b0);
        chk("t4_gate_a", p_m_valid, 32'd0);
        step();
        send_p(8'h02, 1'b0);
        chk("t4_gate_b", p_m_valid, 32'd0);
        step();
        send_p(8'h03, 1'b1);
        chk("t4_gate_c", p_m_valid, 32'd0);
        chk("t4_cnt_one", p_pkt_cnt, 32'd1);
        step();
        chk("t4_beat1", {p_m_valid, p_m_last, p_m_data}, {2'b10, 8'h01});
        step();
        chk("t4_beat2", {p_m_valid, p_m_last, p_m_data}, {2'b10, 8'h02});
        step();
        chk("t4_beat3", {p_m_valid, p_m_last, p_m_data}, {2'b11, 8'h03});
        chk("t4_cnt_held", p_pkt_cnt, 32'd1);
        step();
        chk("t4_done", {p_m_valid, p_pkt_cnt}, 32'd0);
        drain();

        // Test 5: oversize packet forces release with a single overrun pulse.
        ovr0 = ovr_p;
        p_m_ready = 1'b1;
        for (int b = 1; b <= 6; b++) begin
            send_p(8'(b), (b == 6));
            if (b == 4) chk("t5_full", p_level, 32'd4);
        end
        drain();
        chk("t5_overrun_once", ovr_p - ovr0, 32'd1);
        chk("t5_pkt_cnt_end", p_pkt_cnt, 32'd0);

        // Test 6: reset mid-stream discards held beats.
        c_m_ready = 1'b0;
        send_c(8'hC1, 1'b0);
        send_c(8'hC2, 1'b0);
        send_c(8'hC3, 1'b0);
        chk("t6_level3", c_level, 32'd3);
        do_reset();
        chk("t6_level0", c_level, 32'd0);
        c_m_ready = 1'b1;
        send_c(8'h5A, 1'b0);
        chk("t6_first", {c_m_valid, c_m_data}, {1'b1, 8'h5A});
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
